// File: rtl/uart_dbg_master_if.sv
// ---------------------------------------------------------------------------
// uart_dbg_master_if
// Bus-side bundle between the UART debug master and the core's
// peripheral/memory bus.
//   mem_wr_en_o    master -> slave  one-cycle write strobe
//   mem_wr_addr_o  master -> slave  write address (holds between writes)
//   mem_wr_data_o  master -> slave  write data (holds between writes)
//   mem_rd_addr_o  master -> slave  read address (holds between reads)
//   mem_rd_data_i  slave -> master  read data, valid one cycle after address
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_dbg_master_if;
  logic        mem_wr_en_o;
  logic [31:0] mem_wr_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [31:0] mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;

  modport master (
    output mem_wr_en_o,
    output mem_wr_addr_o,
    output mem_wr_data_o,
    output mem_rd_addr_o,
    input  mem_rd_data_i
  );

  modport slave (
    input  mem_wr_en_o,
    input  mem_wr_addr_o,
    input  mem_wr_data_o,
    input  mem_rd_addr_o,
    output mem_rd_data_i
  );
endinterface

// File: rtl/uart_dbg_master.sv
// ---------------------------------------------------------------------------
// uart_dbg_master
// UART-driven bus initiator for host debug and program download. A host sends
//   A5 a0 a1 a2 a3 d0 d1 d2 d3  -> single write, answered with 06 (ACK)
//   5A a0 a1 a2 a3              -> single read, answered with 4 data bytes
//   any other command byte      -> answered with 15 (NAK)
// Multi-byte fields travel LSB first.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   uart_rx_i    serial in (idle high)
//   uart_tx_o    serial out (idle high)
//   busy_o       a command is being collected, executed or answered
//   frame_err_o  one-cycle pulse when a received stop bit is 0
//   bus          uart_dbg_master_if.master (memory write/read port)
//
// Optional feature: define UART_DBG_TIMEOUT_EN to abandon a partially
// received command after TIMEOUT_BAUDS bit periods of silence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_dbg_master #(
  parameter int CLK_FREQ      = 50000000,
  parameter int UART_BPS      = 115200,
  parameter int TIMEOUT_BAUDS = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              uart_rx_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              frame_err_o,
  uart_dbg_master_if.master bus
);

  // Bit period in clock cycles; must be at least 4.
  localparam int          DIV_INT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] DIV_M1  = 16'(DIV_INT - 1);
  localparam logic [15:0] HALF_M1 = 16'((DIV_INT / 2) - 1);

  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic       {T_IDLE, T_SEND} tx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_EXEC, P_CAPT, P_RESP} p_state_t;

  // ------------------------------------------------------------------------
  // RX synchronizer and engine
  // ------------------------------------------------------------------------
  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_fall, rx_tick;
  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_valid;
  logic [7:0]  rx_byte;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  // The start bit is re-checked half a bit in; every later sample is one full bit apart.
  assign rx_tick = (rx_state == R_START) ? (rx_cnt == HALF_M1) : (rx_cnt == DIV_M1);
  assign rx_byte = rx_shift;

  // RX state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_state <= R_IDLE;
    else          rx_state <= rx_next;
  end

  // RX next-state logic.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE: begin
        if (rx_fall) rx_next = R_START;
        else         rx_next = R_IDLE;
      end
      R_START: begin
        if (rx_tick) begin
          // Line back high at mid start bit: a glitch, drop it silently.
          if (rx_sync) rx_next = R_IDLE;
          else         rx_next = R_DATA;
        end else begin
          rx_next = R_START;
        end
      end
      R_DATA: begin
        if (rx_tick && (rx_bit == 3'd7)) rx_next = R_STOP;
        else                             rx_next = R_DATA;
      end
      R_STOP: begin
        if (rx_tick) rx_next = R_IDLE;
        else         rx_next = R_STOP;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  // RX bit timing, data shift and byte/framing-error pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_cnt      <= 16'd0;
      rx_bit      <= 3'd0;
      rx_shift    <= 8'd0;
      rx_valid    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err_o <= 1'b0;
      if ((rx_state == R_IDLE) || rx_tick) rx_cnt <= 16'd0;
      else                                 rx_cnt <= rx_cnt + 16'd1;
      case (rx_state)
        R_START: begin
          if (rx_tick) rx_bit <= 3'd0;
        end
        R_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end
        end
        R_STOP: begin
          if (rx_tick) begin
            if (rx_sync) rx_valid    <= 1'b1;
            else         frame_err_o <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // TX engine
  // ------------------------------------------------------------------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [9:0]  tx_frame;
  logic        tx_last, tx_free, tx_start;
  logic [7:0]  tx_data;

  // Final cycle of a stop bit: a new byte may be loaded here so frames abut.
  assign tx_last = (tx_state == T_SEND) && (tx_cnt == DIV_M1) && (tx_bit == 4'd9);
  assign tx_free = (tx_state == T_IDLE) || tx_last;

  // TX state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tx_state <= T_IDLE;
    else          tx_state <= tx_next;
  end

  // TX next-state logic.
  always_comb begin
    tx_next = tx_state;
    if (tx_start)     tx_next = T_SEND;
    else if (tx_last) tx_next = T_IDLE;
    else              tx_next = tx_state;
  end

  // TX frame shifter; uart_tx_o is registered and returns high on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_cnt    <= 16'd0;
      tx_bit    <= 4'd0;
      tx_frame  <= 10'h3FF;
      uart_tx_o <= 1'b1;
    end else if (tx_start) begin
      tx_frame  <= {1'b1, tx_data, 1'b0};
      tx_cnt    <= 16'd0;
      tx_bit    <= 4'd0;
      uart_tx_o <= 1'b0;
    end else if (tx_state == T_SEND) begin
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= 16'd0;
        if (tx_bit == 4'd9) begin
          uart_tx_o <= 1'b1;
        end else begin
          tx_bit    <= tx_bit + 4'd1;
          uart_tx_o <= tx_frame[1];
          tx_frame  <= {1'b1, tx_frame[9:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end else begin
      uart_tx_o <= 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Command parser
  // ------------------------------------------------------------------------
  p_state_t    p_state, p_next;
  logic        is_wr;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_sh, data_sh, resp;
  logic [2:0]  resp_left;
  logic        tmo_hit;

`ifdef UART_DBG_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BAUDS * DIV_INT);
  logic [31:0] tmo_cnt;
  logic        collecting;

  assign collecting = (p_state == P_ADDR) || (p_state == P_DATA);
  assign tmo_hit    = collecting && (tmo_cnt == (TMO_LIMIT - 32'd1));

  // Cycles since the last received byte while a command is partially collected.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                   tmo_cnt <= 32'd0;
    else if (!collecting || rx_valid) tmo_cnt <= 32'd0;
    else if (!tmo_hit)              tmo_cnt <= tmo_cnt + 32'd1;
    else                            tmo_cnt <= tmo_cnt;
  end
`else
  // No timeout counter: a partial command waits for its remaining bytes.
  // The compare is false for every meaningful (non-negative) setting.
  assign tmo_hit = (TIMEOUT_BAUDS < 0);
`endif

  // Parser state register and busy flag (busy tracks the next state so it
  // rises with command acceptance and falls on re-entry to P_IDLE).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_state <= P_IDLE;
      busy_o  <= 1'b0;
    end else begin
      p_state <= p_next;
      busy_o  <= (p_next != P_IDLE);
    end
  end

  // Parser next-state logic and TX byte hand-off.
  always_comb begin
    p_next   = p_state;
    tx_start = 1'b0;
    tx_data  = resp[7:0];
    case (p_state)
      P_IDLE: begin
        if (rx_valid) begin
          if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) p_next = P_ADDR;
          else                                            p_next = P_RESP;
        end else begin
          p_next = P_IDLE;
        end
      end
      P_ADDR, P_DATA: begin
        if (frame_err_o) begin
          p_next = P_IDLE;
        end else if (rx_valid) begin
          if (byte_cnt == 2'd3) begin
            if ((p_state == P_DATA) || !is_wr) p_next = P_EXEC;
            else                               p_next = P_DATA;
          end else begin
            p_next = p_state;
          end
        end else if (tmo_hit) begin
          p_next = P_IDLE;
        end else begin
          p_next = p_state;
        end
      end
      P_EXEC: begin
        if (is_wr) p_next = P_RESP;
        else       p_next = P_CAPT;
      end
      P_CAPT: p_next = P_RESP;
      P_RESP: begin
        if (resp_left != 3'd0) begin
          tx_start = tx_free;
          p_next   = P_RESP;
        end else if (tx_free) begin
          // Last stop bit is completing this cycle.
          p_next = P_IDLE;
        end else begin
          p_next = P_RESP;
        end
      end
      default: p_next = P_IDLE;
    endcase
  end

  // Parser datapath: field assembly, bus outputs and response buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      is_wr             <= 1'b0;
      byte_cnt          <= 2'd0;
      addr_sh           <= 32'd0;
      data_sh           <= 32'd0;
      resp              <= 32'd0;
      resp_left         <= 3'd0;
      bus.mem_wr_en_o   <= 1'b0;
      bus.mem_wr_addr_o <= 32'd0;
      bus.mem_wr_data_o <= 32'd0;
      bus.mem_rd_addr_o <= 32'd0;
    end else begin
      bus.mem_wr_en_o <= 1'b0;
      case (p_state)
        P_IDLE: begin
          if (rx_valid) begin
            is_wr    <= (rx_byte == CMD_WR);
            byte_cnt <= 2'd0;
            if ((rx_byte != CMD_WR) && (rx_byte != CMD_RD)) begin
              resp      <= {24'd0, RSP_NAK};
              resp_left <= 3'd1;
            end
          end
        end
        P_ADDR: begin
          if (rx_valid) begin
            addr_sh  <= {rx_byte, addr_sh[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            // Present the read address on entry to P_EXEC.
            if ((byte_cnt == 2'd3) && !is_wr) bus.mem_rd_addr_o <= {rx_byte, addr_sh[31:8]};
          end
        end
        P_DATA: begin
          if (rx_valid) begin
            data_sh  <= {rx_byte, data_sh[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            // Address, data and strobe land together; strobe lasts the P_EXEC cycle only.
            if (byte_cnt == 2'd3) begin
              bus.mem_wr_addr_o <= addr_sh;
              bus.mem_wr_data_o <= {rx_byte, data_sh[31:8]};
              bus.mem_wr_en_o   <= 1'b1;
            end
          end
        end
        P_EXEC: begin
          if (is_wr) begin
            resp      <= {24'd0, RSP_ACK};
            resp_left <= 3'd1;
          end
        end
        P_CAPT: begin
          resp      <= bus.mem_rd_data_i;
          resp_left <= 3'd4;
        end
        P_RESP: begin
          if (tx_start) begin
            resp      <= {8'd0, resp[31:8]};
            resp_left <= resp_left - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/uart_dbg_master.md
Name: uart_dbg_master

Overview:
- UART-driven bus initiator for host debug and program download.
- Receives framed command bytes on a serial line, then issues single-word writes or reads on the core's peripheral/memory bus.
- Returns read data or a status byte over its own TX line.
- It is the counterpart of the memory-mapped UART responder: this block drives the bus, the peripheral answers it.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, serial bit rate.
- TIMEOUT_BAUDS, 64, inter-byte timeout in bit periods (used only with the optional feature).

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset: asynchronous, active-low.
- uart_rx_i  input  1  serial in, idle high.
- uart_tx_o  output  1  serial out, idle high.
- mem_wr_en_o  output  1  one-cycle write strobe.
- mem_wr_addr_o  output  32  write address.
- mem_wr_data_o  output  32  write data.
- mem_rd_addr_o  output  32  read address.
- mem_rd_data_i  input  32  read data, valid one cycle after mem_rd_addr_o.
- busy_o  output  1  transaction in progress (core may stall on it).
- frame_err_o  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset: all outputs 0 except uart_tx_o=1; all FSMs idle; counters 0.
- DIV = CLK_FREQ/UART_BPS, held in a 16-bit counter; DIV must be at least 4.

RX engine:
- uart_rx_i passes through a 2-flop synchronizer.
- A falling edge while idle starts the receiver.
- Start bit is re-checked at DIV/2 cycles; if it is high, abort silently (glitch rejection).
- 8 data bits sampled LSB first at mid-bit, every DIV cycles; then the stop bit is sampled.
- Stop bit 1: rx_valid pulses for 1 cycle with the byte.
- Stop bit 0: frame_err_o pulses, the byte is dropped, and the parser returns to P_IDLE.

TX engine:
- Frame is start 0, 8 bits LSB first, stop 1, each bit DIV cycles: 10*DIV cycles per byte.
- Bytes go back-to-back with no idle gap.

Parser FSM:
- P_IDLE:
  - 0xA5 -> P_ADDR (write).
  - 0x5A -> P_ADDR (read).
  - Any other byte -> P_RESP with 0x15 (NAK).
- P_ADDR: collect 4 bytes LSB first -> P_DATA for a write, P_EXEC for a read.
- P_DATA: collect 4 bytes LSB first -> P_EXEC.
- P_EXEC, write:
  - mem_wr_en_o=1 for exactly 1 cycle with address and data stable.
  - Response is 0x06 (ACK).
- P_EXEC, read:
  - Cycle N: mem_rd_addr_o is driven.
  - Cycle N+1: mem_rd_data_i is captured.
  - Response is the 4 data bytes LSB first.
- P_RESP: transmit the response bytes -> P_IDLE after the last stop bit completes.

Bus and status outputs:
- mem_wr_addr_o, mem_wr_data_o and mem_rd_addr_o hold their last values between transactions.
- busy_o rises the cycle after the command byte is accepted.
- busy_o falls when the parser re-enters P_IDLE.
- busy_o also rises for a NAK response.

Boundary conditions:
- Bytes received during P_EXEC/P_RESP are discarded; the host waits for the response.
- Reset mid-operation: uart_tx_o returns to 1 immediately (asynchronously), any in-progress frame is abandoned, and no write strobe is issued.
- Address 0xFFFFFFFF is legal; there is no alignment check.

Optional Feature:
- Macro: UART_DBG_TIMEOUT_EN.
- Defined:
  - While in P_ADDR/P_DATA, a counter measures cycles since the last rx_valid.
  - Reaching TIMEOUT_BAUDS*DIV cycles returns the parser to P_IDLE with no bus access and no response.
  - busy_o drops on that same transition to P_IDLE.
- Undefined:
  - No counter exists.
  - A partial command waits indefinitely for its remaining bytes.

Test Plan:
Bench uses CLK_FREQ=1000000, UART_BPS=100000 (DIV=10).
- Write: send A5 78 56 34 12 EF BE AD DE -> mem_wr_en_o high 1 cycle with addr 0x12345678, data 0xDEADBEEF; TX returns 0x06; busy_o low afterwards.
- Read: send 5A 10 00 00 00 with the bench returning 0xCAFEF00D one cycle after mem_rd_addr_o=0x00000010 -> TX bytes 0D F0 FE CA in order, 40*DIV cycles total.
- Bad command: send 0x33 -> TX 0x15; mem_wr_en_o never asserted; parser ready for the next command.
- Framing and glitch:
  - Pull uart_rx_i low for 3 cycles -> no byte received.
  - Send A5 78 56 with a stop bit of 0 on 0x56 -> frame_err_o 1-cycle pulse, parser idle.
  - Then a full valid write -> succeeds.
- Reset mid-response: assert rst_n_i during the 2nd read-data byte -> uart_tx_o=1 and busy_o=0 asynchronously; no further TX activity.
- Timeout (UART_DBG_TIMEOUT_EN, TIMEOUT_BAUDS=64): send A5 01 02 then idle for 640 cycles -> busy_o low, no response; a following read of 0x00000004 completes normally.
